// File: rtl/sram_port_ctrl_if.sv
// sram_port_ctrl_if: single-word request/acknowledge bus between memory manager and SRAM sequencer
// Ports (all signals): req, we, addr[19:0], wdata[31:0], be[3:0] from requester;
//                      ack, rdata[31:0], busy from sequencer.
interface sram_port_ctrl_if;
   logic        req;
   logic        we;
   logic [19:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        ack;
   logic [31:0] rdata;
   logic        busy;
   modport master (output req, we, addr, wdata, be, input ack, rdata, busy);
   modport slave (input req, we, addr, wdata, be, output ack, rdata, busy);
endinterface

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: cycle-level timing sequencer for one asynchronous 32-bit SRAM bank
// Ports: clk, rst (sync, active-high); bus (slave side of sram_port_ctrl_if);
//        sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n to the chip,
//        sram_dq_i from the chip. Every output is a register.
module sram_port_ctrl #(
   parameter int RD_CYC = 2,
   parameter int WR_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   sram_port_ctrl_if.slave      bus,
   output logic [19:0]          sram_addr,
   output logic [31:0]          sram_dq_o,
   input  logic [31:0]          sram_dq_i,
   output logic                 sram_dq_oe,
   output logic                 sram_ce_n,
   output logic                 sram_oe_n,
   output logic                 sram_we_n,
   output logic [3:0]           sram_be_n
);
   localparam int RD = (RD_CYC < 1) ? 1 : RD_CYC;
   localparam int WR = (WR_CYC < 1) ? 1 : WR_CYC;
   localparam logic [3:0] RD_CNT = 4'(RD - 1);
   localparam logic [3:0] WR_CNT = 4'(WR - 1);
   typedef enum logic [2:0] {IDLE, RD_S, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
   state_t     state;
   logic [3:0] cnt;
   // The pin registers themselves hold the latched request, so later
   // changes on the bus inputs cannot disturb an access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         sram_addr  <= 20'd0;
         sram_dq_o  <= 32'd0;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_be_n  <= 4'hF;
         bus.ack    <= 1'b0;
         bus.busy   <= 1'b0;
         bus.rdata  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               bus.ack <= 1'b0;
               // Blocking acceptance during the ack cycle forces one turnaround cycle.
               if (bus.req && !bus.ack) begin
                  bus.busy  <= 1'b1;
                  sram_addr <= bus.addr;
                  sram_ce_n <= 1'b0;
                  if (bus.we) begin
                     sram_dq_o  <= bus.wdata;
                     sram_dq_oe <= 1'b1;
                     sram_be_n  <= ~bus.be;
                     sram_we_n  <= 1'b1;
                     state      <= WR_SETUP;
                  end else begin
                     sram_oe_n <= 1'b0;
                     sram_be_n <= 4'h0;
                     cnt       <= RD_CNT;
                     state     <= RD_S;
                  end
               end else begin
                  bus.busy <= 1'b0;
               end
            end
            RD_S: begin
               if (cnt == 4'd0) begin
                  bus.rdata <= sram_dq_i;
                  bus.ack   <= 1'b1;
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  sram_be_n <= 4'hF;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            WR_SETUP: begin
               sram_we_n <= 1'b0;
               cnt       <= WR_CNT;
               state     <= WR_PULSE;
            end
            WR_PULSE: begin
               if (cnt == 4'd0) begin
                  sram_we_n <= 1'b1;
                  state     <= WR_HOLD;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            WR_HOLD: begin
               bus.ack    <= 1'b1;
               sram_dq_oe <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_be_n  <= 4'hF;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: scoreboard bench for sram_port_ctrl, one instance at RD/WR=2/2 and one at 1/5
module tb_sram_port_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   logic        req [2];
   logic        we [2];
   logic [19:0] addr [2];
   logic [31:0] wdata [2];
   logic [3:0]  be [2];
   logic        ack [2];
   logic [31:0] rdata [2];
   logic        busy [2];
   logic [19:0] s_addr [2];
   logic [31:0] dq_o [2];
   logic [31:0] dq_i [2];
   logic        dq_oe [2];
   logic        ce_n [2];
   logic        oe_n [2];
   logic        we_n [2];
   logic [3:0]  be_n [2];
   int rdc [2] = '{2, 1};
   int wrc [2] = '{2, 5};
   logic [31:0] last_rd [2];
   int n_chk = 0;
   int n_fail = 0;
   sram_port_ctrl_if ifa ();
   sram_port_ctrl_if ifb ();
   assign ifa.req = req[0];
   assign ifa.we = we[0];
   assign ifa.addr = addr[0];
   assign ifa.wdata = wdata[0];
   assign ifa.be = be[0];
   assign ack[0] = ifa.ack;
   assign rdata[0] = ifa.rdata;
   assign busy[0] = ifa.busy;
   assign ifb.req = req[1];
   assign ifb.we = we[1];
   assign ifb.addr = addr[1];
   assign ifb.wdata = wdata[1];
   assign ifb.be = be[1];
   assign ack[1] = ifb.ack;
   assign rdata[1] = ifb.rdata;
   assign busy[1] = ifb.busy;
   sram_port_ctrl #(.RD_CYC(2), .WR_CYC(2)) u_a (
      .clk(clk), .rst(rst), .bus(ifa.slave),
      .sram_addr(s_addr[0]), .sram_dq_o(dq_o[0]), .sram_dq_i(dq_i[0]), .sram_dq_oe(dq_oe[0]),
      .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_be_n(be_n[0]));
   sram_port_ctrl #(.RD_CYC(1), .WR_CYC(5)) u_b (
      .clk(clk), .rst(rst), .bus(ifb.slave),
      .sram_addr(s_addr[1]), .sram_dq_o(dq_o[1]), .sram_dq_i(dq_i[1]), .sram_dq_oe(dq_oe[1]),
      .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_be_n(be_n[1]));
   typedef struct {
      int          waits;
      int          ackc;
      logic [31:0] oem;
      logic [31:0] wem;
      logic [31:0] dqm;
      logic [31:0] bsm;
      logic [31:0] rdata;
      logic [3:0]  ben;
   } exp_t;
   exp_t sb[$];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check("oe_dq_overlap", {31'd0, !oe_n[i] && dq_oe[i]}, 32'd0);
         check("dq_oe_without_ce", {31'd0, dq_oe[i] && ce_n[i]}, 32'd0);
      end
   end
   // Cycle k=1 is the first cycle after the accepting edge.
   task automatic run_access(input int i, input logic w, input logic [19:0] a, input logic [31:0] d,
                             input logic [3:0] b, input logic [31:0] dqi, input bit keep,
                             input bit b2b, input bit chg);
      exp_t e;
      int n;
      int k;
      int ackc;
      logic [31:0] oem, wem, dqm, bsm;
      bit addr_bad, ben_bad, dq_bad;
      e.waits = b2b ? 2 : 1;
      e.ackc = w ? wrc[i] + 3 : rdc[i] + 1;
      e.oem = w ? 32'd0 : ((32'd1 << rdc[i]) - 32'd1) << 1;
      e.wem = w ? ((32'd1 << wrc[i]) - 32'd1) << 2 : 32'd0;
      e.dqm = w ? ((32'd1 << (wrc[i] + 2)) - 32'd1) << 1 : 32'd0;
      e.bsm = ((32'd1 << e.ackc) - 32'd1) << 1;
      e.ben = w ? ~b : 4'h0;
      if (!w) last_rd[i] = dqi;
      e.rdata = last_rd[i];
      sb.push_back(e);
      req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b; dq_i[i] = dqi;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (ce_n[i] && n < 10);
      k = 1; ackc = 0; oem = 0; wem = 0; dqm = 0; bsm = 0;
      addr_bad = 0; ben_bad = 0; dq_bad = 0;
      while (ackc == 0 && k < 30) begin
         oem[k] = !oe_n[i];
         wem[k] = !we_n[i];
         dqm[k] = dq_oe[i];
         bsm[k] = busy[i];
         if (ack[i]) begin
            ackc = k;
         end else begin
            if (s_addr[i] !== a) addr_bad = 1;
            if (be_n[i] !== e.ben) ben_bad = 1;
            if (w && dq_o[i] !== d) dq_bad = 1;
            if (chg && k == 3) addr[i] = a ^ 20'h00070;
            @(posedge clk); #1; k++;
         end
      end
      e = sb.pop_front();
      check("accept_edges", n, e.waits);
      check("ack_cycle", ackc, e.ackc);
      check("oe_n_low_cycles", oem, e.oem);
      check("we_n_low_cycles", wem, e.wem);
      check("dq_oe_cycles", dqm, e.dqm);
      check("busy_cycles", bsm, e.bsm);
      check("addr_stable", {31'd0, addr_bad}, 32'd0);
      check("be_n_stable", {31'd0, ben_bad}, 32'd0);
      check("dq_o_stable", {31'd0, dq_bad}, 32'd0);
      check("rdata", rdata[i], e.rdata);
      check("ce_n_at_ack", {31'd0, ce_n[i]}, 32'd1);
      check("be_n_at_ack", {28'd0, be_n[i]}, 32'hF);
      if (!keep) begin
         req[i] = 1'b0;
         @(posedge clk); #1;
         check("busy_after_ack", {31'd0, busy[i]}, 32'd0);
         check("ack_one_cycle", {31'd0, ack[i]}, 32'd0);
      end
   endtask
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bit seen;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; we[i] = 0; addr[i] = 0; wdata[i] = 0; be[i] = 0; dq_i[i] = 0; last_rd[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_ce_n", {31'd0, ce_n[i]}, 32'd1);
         check("rst_oe_n", {31'd0, oe_n[i]}, 32'd1);
         check("rst_we_n", {31'd0, we_n[i]}, 32'd1);
         check("rst_be_n", {28'd0, be_n[i]}, 32'hF);
         check("rst_dq_oe", {31'd0, dq_oe[i]}, 32'd0);
         check("rst_addr", {12'd0, s_addr[i]}, 32'd0);
         check("rst_dq_o", dq_o[i], 32'd0);
         check("rst_ack", {31'd0, ack[i]}, 32'd0);
         check("rst_busy", {31'd0, busy[i]}, 32'd0);
         check("rst_rdata", rdata[i], 32'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      run_access(0, 1'b0, 20'h00010, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 0);
      run_access(0, 1'b1, 20'h00020, 32'h12345678, 4'b0101, 32'h0, 0, 0, 0);
      run_access(0, 1'b1, 20'h00050, 32'hA5A5_5A5A, 4'b1111, 32'h0, 1, 0, 0);
      run_access(0, 1'b0, 20'h00060, 32'h0, 4'h0, 32'hCAFEF00D, 0, 1, 0);
      run_access(0, 1'b1, 20'h00030, 32'h0F0F_0F0F, 4'b0011, 32'h0, 0, 0, 1);
      run_access(0, 1'b1, 20'h00070, 32'h1111_2222, 4'b0000, 32'h0, 0, 0, 0);
      run_access(1, 1'b0, 20'h00005, 32'h0, 4'h0, 32'h0BADF00D, 0, 0, 0);
      run_access(1, 1'b1, 20'h00006, 32'h7654_3210, 4'b1001, 32'h0, 0, 0, 0);
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 20'h00080; dq_i[0] = 32'h5555AAAA;
      @(posedge clk); #1;
      check("mid_rst_accepted", {31'd0, ce_n[0]}, 32'd0);
      rst = 1'b1; req[0] = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_ce_n", {31'd0, ce_n[0]}, 32'd1);
      check("mid_rst_oe_n", {31'd0, oe_n[0]}, 32'd1);
      check("mid_rst_be_n", {28'd0, be_n[0]}, 32'hF);
      check("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
      check("mid_rst_rdata", rdata[0], 32'd0);
      rst = 1'b0;
      seen = ack[0];
      repeat (10) begin
         @(posedge clk); #1;
         seen |= ack[0];
      end
      check("mid_rst_no_ack", {31'd0, seen}, 32'd0);
      check("mid_rst_rdata_held", rdata[0], 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
